// File: rtl/up_down_counter.sv
// Parameterised up/down counter with synchronous load, boundary flags and a registered wrap pulse.
// Define UP_DOWN_COUNTER_SAT_EN to saturate at the boundaries instead of wrapping.
module up_down_counter #(
   parameter int              WIDTH = 3,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap
);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap_next;
   logic [WIDTH:0]   w_step;

   // Returns {boundary_hit, next_count} for one enabled step in direction up.
   function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] cnt, input logic up);
      logic             at_edge;
      logic [WIDTH-1:0] nxt;
      at_edge = up ? (cnt == '1) : (cnt == '0);
      nxt     = up ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
`ifdef UP_DOWN_COUNTER_SAT_EN
      if (at_edge) nxt = cnt;
`else
`endif
      return {at_edge, nxt};
   endfunction

   assign w_step = f_step(r_count, mode);

   always_comb begin
      w_next      = r_count;
      w_wrap_next = 1'b0;
      if (load) begin
         w_next = din;
      end else if (en) begin
         w_next      = w_step[WIDTH-1:0];
         w_wrap_next = w_step[WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= INIT;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_next;
         r_wrap  <= w_wrap_next;
      end
   end

   assign count  = r_count;
   assign wrap   = r_wrap;
   assign at_max = (r_count == '1);
   assign at_min = (r_count == '0);

endmodule

// File: tb/tb_up_down_counter.sv
// Randomised self-checking bench for up_down_counter against an integer-arithmetic reference model.
// Honours UP_DOWN_COUNTER_SAT_EN in the model so either build can be checked.
module tb_up_down_counter;

   localparam int W    = 3;
   localparam int MAXV = (1 << W) - 1;

   logic         clk;
   logic         rst;
   logic         mode;
   logic         en;
   logic         load;
   logic [W-1:0] din;
   logic [W-1:0] count;
   logic         at_max;
   logic         at_min;
   logic         wrap;

   int n_cmp;
   int n_err;
   int m_count;
   int m_wrap;

   up_down_counter #(.WIDTH(W), .INIT('0)) dut (
      .clk    (clk),
      .rst    (rst),
      .mode   (mode),
      .en     (en),
      .load   (load),
      .din    (din),
      .count  (count),
      .at_max (at_max),
      .at_min (at_min),
      .wrap   (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour: plain integer arithmetic on the sampled inputs.
   task automatic model_edge();
      int nxt;
      if (!rst) begin
         m_count = 0;
         m_wrap  = 0;
      end else if (load) begin
         m_count = int'(din);
         m_wrap  = 0;
      end else if (en) begin
         nxt    = mode ? m_count + 1 : m_count - 1;
         m_wrap = (nxt < 0 || nxt > MAXV) ? 1 : 0;
`ifdef UP_DOWN_COUNTER_SAT_EN
         if (m_wrap == 0) m_count = nxt;
`else
         m_count = (nxt + MAXV + 1) % (MAXV + 1);
`endif
      end else begin
         m_wrap = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"},  int'(count),  m_count);
      chk({tag, ".wrap"},   int'(wrap),   m_wrap);
      chk({tag, ".at_max"}, int'(at_max), (m_count == MAXV) ? 1 : 0);
      chk({tag, ".at_min"}, int'(at_min), (m_count == 0) ? 1 : 0);
   endtask

   task automatic step(input string tag, input logic i_ld, input logic i_en,
                       input logic i_md, input logic [W-1:0] i_d);
      load = i_ld;
      en   = i_en;
      mode = i_md;
      din  = i_d;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear before the next edge.
   task automatic mid_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      m_count = 0;
      m_wrap  = 0;
      check_all(tag);
      #2 rst = 1'b1;
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      m_count = 0;
      m_wrap  = 0;
      rst     = 1'b0;
      load    = 1'b0;
      en      = 1'b1;
      mode    = 1'b1;
      din     = '0;

      #1;
      check_all("rst_async");
      for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b1, 1'b1, '0);
      chk("rst_at_min_const", int'(at_min), 1);

      rst = 1'b1;
      for (int i = 0; i < 9; i++) step("up", 1'b0, 1'b1, 1'b1, '0);
      chk("up_end_const", int'(count), 1);

      step("up_to2", 1'b0, 1'b1, 1'b1, '0);
      for (int i = 0; i < 4; i++) step("down", 1'b0, 1'b1, 1'b0, '0);
`ifndef UP_DOWN_COUNTER_SAT_EN
      chk("down_end_const", int'(count), 6);
`endif

      step("dir_load4", 1'b1, 1'b0, 1'b0, W'(4));
      step("dir_up5",   1'b0, 1'b1, 1'b1, '0);
      step("dir_dn4",   1'b0, 1'b1, 1'b0, '0);
      step("dir_up5b",  1'b0, 1'b1, 1'b1, '0);
      chk("dir_const", int'(count), 5);

      for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 1'b1, '0);
      step("load_prio", 1'b1, 1'b1, 1'b0, W'(6));
      chk("load_prio_const", int'(count), 6);
      step("after_load", 1'b0, 1'b1, 1'b0, '0);
      chk("after_load_const", int'(count), 5);

      step("to_max_a", 1'b0, 1'b1, 1'b1, '0);
      step("to_max_b", 1'b0, 1'b1, 1'b1, '0);
      for (int i = 0; i < 3; i++) step("edge_up", 1'b0, 1'b1, 1'b1, '0);
      step("zero_load", 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 2; i++) step("edge_dn", 1'b0, 1'b1, 1'b0, '0);

      step("pre_midrst", 1'b0, 1'b1, 1'b1, '0);
      mid_reset("mid_rst");
      step("post_midrst", 1'b0, 1'b1, 1'b1, '0);

      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), W'($urandom));
         if ($urandom_range(0, 49) == 0) mid_reset("rand_rst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Parameterised binary up/down counter with synchronous load, count enable, boundary flags and a registered wrap pulse.
- Used as a general-purpose event, position or index counter in datapath and control logic.
- Direction is selected each cycle by `mode`: 1 = up, 0 = down.

Parameters:
- WIDTH, 3, counter width in bits (≥ 1).
- INIT, 0, value loaded on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- mode  input  1  direction; 1 = count up, 0 = count down.
- en  input  1  count enable; counter holds when 0.
- load  input  1  synchronous load strobe.
- din  input  WIDTH  value loaded when load = 1.
- count  output  WIDTH  current count, registered.
- at_max  output  1  high when count = all-ones; combinational decode of count.
- at_min  output  1  high when count = 0; combinational decode of count.
- wrap  output  1  registered one-cycle pulse on a boundary crossing.

Behaviour:
- Reset
  - rst = 0 asserts immediately, independent of clk: count = INIT, wrap = 0.
  - Deassertion is sampled at the next rising clk edge; the first count update happens on the first rising edge with rst = 1.
- Per-cycle update on rising clk edge with rst = 1, in priority order:
  - load = 1: count <= din, wrap <= 0; en and mode are ignored.
  - else en = 1 and mode = 1: count <= count + 1, modulo 2^WIDTH.
  - else en = 1 and mode = 0: count <= count − 1, modulo 2^WIDTH.
  - else: count holds, wrap <= 0.
- Wrap-around (default build)
  - Up from 2^WIDTH−1 gives 0, and wrap <= 1 for exactly one cycle.
  - Down from 0 gives 2^WIDTH−1, and wrap <= 1 for exactly one cycle.
  - Every other count step gives wrap <= 0.
- Direction change: mode may toggle on any cycle. The next edge uses the new direction with no dead cycle; there is no latency beyond one clock.
- at_max / at_min
  - Pure decodes of the current count, valid in the same cycle as count.
  - With WIDTH = 1 they are mutually exclusive; this holds for any WIDTH.
- Reset mid-operation: an asynchronous rst = 0 overrides load and en instantly; an in-flight wrap pulse is cleared.
- Inputs are assumed synchronous to clk; there is no internal synchronisation.
- Arithmetic is unsigned and WIDTH bits wide; carry and borrow are not exported except through wrap.

Optional Feature:
- Macro: UP_DOWN_COUNTER_SAT_EN.
- Defined (saturating build):
  - Counting up at 2^WIDTH−1 holds the value.
  - Counting down at 0 holds 0.
  - wrap is repurposed as a one-cycle "saturation hit" pulse: it asserts on any enabled step attempted at the boundary in the current direction.
  - load is unaffected.
- Not defined: modulo wrap-around as described under Behaviour.
- Port list is identical in both builds.

Test Plan:
- Reset: rst = 0 with clk running, mode = 1, en = 1 → count = 0, wrap = 0, at_min = 1. Assert rst mid-cycle → count goes to 0 before the next edge.
- Up count (WIDTH = 3): release rst, en = 1, mode = 1 for 9 edges → count 1,2,…,7,0,1; wrap high only in the cycle after 7→0; at_max high while count = 7.
- Down count: from count = 2, mode = 0 for 4 edges → 1,0,7,6; wrap pulses once after 0→7; at_min high while count = 0.
- Direction switch: up to 5, toggle mode = 0 → next edge gives 4; toggle back → 5. No skipped or stalled cycle.
- Enable and load priority: en = 0 for 3 edges → count holds. load = 1, din = 6, en = 1, mode = 0 → count = 6 and wrap = 0. Next edge, down with load = 0 → 5.
- SAT_EN build: count up from 6 → 7,7,7 with a wrap pulse on each blocked step. mode = 0 from 0 → stays 0 with a wrap pulse.
